// File: rtl/exec_unit.sv
// exec_unit: multi-cycle ALU/shift/multiply execute stage feeding an 8x16 register file.
// Define EXEC_FAST_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module exec_unit #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [SEL_W-1:0] destSel,
    output logic             busy,
    output logic [SEL_W-1:0] wbSel,
    output logic [WIDTH-1:0] wbData,
    output logic             wbLoad,
    output logic             zero,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   wb_sel_q, wb_sel_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;
    logic               wb_load_q, wb_load_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
`ifndef EXEC_FAST_SHIFT_EN
    logic               carry_int_q, carry_int_d;
`endif

    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               done;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   k_in;

    assign k_in = opB[CNT_W-1:0];

    // Next-state, datapath step and write-back register updates.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sel_d     = sel_q;
        wb_sel_d  = wb_sel_q;
        wb_data_d = wb_data_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
`ifndef EXEC_FAST_SHIFT_EN
        carry_int_d = carry_int_q;
`endif
        res  = '0;
        res_c = 1'b0;
        done = 1'b0;
        sum  = '0;
        prod = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    op_d    = op_e'(op);
                    a_d     = opA;
                    b_d     = opB;
                    sel_d   = destSel;
                    acc_d   = {{WIDTH{1'b0}}, opB};
`ifndef EXEC_FAST_SHIFT_EN
                    carry_int_d = 1'b0;
`endif
                    if (op_e'(op) == OP_MUL) begin
                        cnt_d = CNT_W'(WIDTH - 1);
`ifndef EXEC_FAST_SHIFT_EN
                    end else if (op_e'(op) == OP_SHL || op_e'(op) == OP_SHR) begin
                        cnt_d = k_in;
`endif
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_ADD: begin
                        {res_c, res} = {1'b0, a_q} + {1'b0, b_q};
                        done = 1'b1;
                    end
                    OP_SUB: begin
                        {res_c, res} = {1'b0, a_q} - {1'b0, b_q};
                        done = 1'b1;
                    end
                    OP_AND: begin
                        res  = a_q & b_q;
                        done = 1'b1;
                    end
                    OP_OR: begin
                        res  = a_q | b_q;
                        done = 1'b1;
                    end
                    OP_XOR: begin
                        res  = a_q ^ b_q;
                        done = 1'b1;
                    end
                    OP_SHL, OP_SHR: begin
`ifdef EXEC_FAST_SHIFT_EN
                        // Extra guard bit catches the last bit shifted out.
                        if (op_q == OP_SHL) begin
                            {res_c, res} = {1'b0, a_q} << b_q[CNT_W-1:0];
                        end else begin
                            {res, res_c} = {a_q, 1'b0} >> b_q[CNT_W-1:0];
                        end
                        done = 1'b1;
`else
                        if (cnt_q == '0) begin
                            res   = a_q;
                            res_c = carry_int_q;
                            done  = 1'b1;
                        end else begin
                            if (op_q == OP_SHL) begin
                                carry_int_d = a_q[WIDTH-1];
                                a_d = a_q << 1;
                            end else begin
                                carry_int_d = a_q[0];
                                a_d = a_q >> 1;
                            end
                            cnt_d = cnt_q - 1'b1;
                        end
`endif
                    end
                    OP_MUL: begin
                        // Right-shifting product: multiplier sits in the low half.
                        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                            + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
                        prod  = {sum, acc_q[WIDTH-1:1]};
                        acc_d = prod;
                        if (cnt_q == '0) begin
                            res   = prod[WIDTH-1:0];
                            res_c = |prod[2*WIDTH-1:WIDTH];
                            done  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: done = 1'b1;
                endcase
                if (done) begin
                    state_d   = S_WB;
                    wb_sel_d  = sel_q;
                    wb_data_d = res;
                    zero_d    = (res == '0);
                    carry_d   = res_c;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        wb_load_d = (state_d == S_WB);
        busy_d    = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            sel_q     <= '0;
            wb_sel_q  <= '0;
            wb_data_q <= '0;
            wb_load_q <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifndef EXEC_FAST_SHIFT_EN
            carry_int_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sel_q     <= sel_d;
            wb_sel_q  <= wb_sel_d;
            wb_data_q <= wb_data_d;
            wb_load_q <= wb_load_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            busy_q    <= busy_d;
`ifndef EXEC_FAST_SHIFT_EN
            carry_int_q <= carry_int_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign wbSel  = wb_sel_q;
    assign wbData = wb_data_q;
    assign wbLoad = wb_load_q;
    assign zero   = zero_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed self-checking bench for exec_unit.
// Expected shift latencies follow EXEC_FAST_SHIFT_EN when defined.
module tb_exec_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [2:0]  destSel;
    logic        busy;
    logic [2:0]  wbSel;
    logic [15:0] wbData;
    logic        wbLoad;
    logic        zero;
    logic        carry;

    int checks = 0;
    int failures = 0;

    exec_unit #(.WIDTH(16), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .opA(opA), .opB(opB), .destSel(destSel),
        .busy(busy), .wbSel(wbSel), .wbData(wbData),
        .wbLoad(wbLoad), .zero(zero), .carry(carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef EXEC_FAST_SHIFT_EN
    localparam int L_SHL1 = 2;
    localparam int L_SHR3 = 2;
`else
    localparam int L_SHL1 = 3;
    localparam int L_SHR3 = 5;
`endif

    // Drive one operation from IDLE and capture the write-back it produces.
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] s, output int lat, output logic [2:0] ws,
                         output logic [15:0] wd, output logic z, output logic c,
                         output logic wl_nx, output logic bz_nx);
        op = o; opA = a; opB = b; destSel = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b000; opA = 16'hDEAD; opB = 16'hBEEF; destSel = 3'd0;
        lat = 0; ws = '0; wd = '0; z = 1'b0; c = 1'b0;
        for (int n = 1; n < 40; n++) begin
            @(posedge clk); #1;
            if (wbLoad) begin
                lat = n + 1; ws = wbSel; wd = wbData; z = zero; c = carry;
                break;
            end
        end
        @(posedge clk); #1;
        wl_nx = wbLoad; bz_nx = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'b0; opA = '0; opB = '0; destSel = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++;
        if ({busy, wbLoad, wbSel, wbData, zero, carry} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b wbLoad=%b wbSel=%0d wbData=%h zero=%b carry=%b required all 0",
                     busy, wbLoad, wbSel, wbData, zero, carry);
        end
    endtask

    task automatic test_add();
        int lat; logic [2:0] ws; logic [15:0] wd; logic z, c, wl, bz;
        issue(3'b000, 16'hFFFF, 16'h0001, 3'd3, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_lat: got %0d required 2", lat); end
        checks++; if (ws !== 3'd3) begin failures++; $display("FAIL add_sel: got %0d required 3", ws); end
        checks++; if (wd !== 16'h0000) begin failures++; $display("FAIL add_data: got %h required 0000", wd); end
        checks++; if (z !== 1'b1) begin failures++; $display("FAIL add_zero: got %b required 1", z); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL add_carry: got %b required 1", c); end
        checks++; if (wl !== 1'b0) begin failures++; $display("FAIL add_pulse: got wbLoad=%b next cycle required 0", wl); end
        checks++; if (bz !== 1'b0) begin failures++; $display("FAIL add_busy: got busy=%b next cycle required 0", bz); end
    endtask

    task automatic test_sub_xor();
        int lat; logic [2:0] ws; logic [15:0] wd; logic z, c, wl, bz;
        issue(3'b001, 16'h0005, 16'h0007, 3'd6, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sub_lat: got %0d required 2", lat); end
        checks++; if (ws !== 3'd6) begin failures++; $display("FAIL sub_sel: got %0d required 6", ws); end
        checks++; if (wd !== 16'hFFFE) begin failures++; $display("FAIL sub_data: got %h required fffe", wd); end
        checks++; if ({z, c} !== 2'b01) begin failures++; $display("FAIL sub_flags: got zero=%b carry=%b required 0 1", z, c); end
        issue(3'b100, 16'hA5A5, 16'hFFFF, 3'd1, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== 2) begin failures++; $display("FAIL xor_lat: got %0d required 2", lat); end
        checks++; if (wd !== 16'h5A5A) begin failures++; $display("FAIL xor_data: got %h required 5a5a", wd); end
        checks++; if ({z, c} !== 2'b00) begin failures++; $display("FAIL xor_flags: got zero=%b carry=%b required 0 0", z, c); end
        issue(3'b011, 16'h00F0, 16'h0F00, 3'd2, lat, ws, wd, z, c, wl, bz);
        checks++; if (wd !== 16'h0FF0) begin failures++; $display("FAIL or_data: got %h required 0ff0", wd); end
        issue(3'b010, 16'h00F0, 16'h0F00, 3'd2, lat, ws, wd, z, c, wl, bz);
        checks++; if ({wd, z} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL and_data: got %h zero=%b required 0000 1", wd, z); end
    endtask

    task automatic test_shift();
        int lat; logic [2:0] ws; logic [15:0] wd; logic z, c, wl, bz;
        issue(3'b101, 16'h8001, 16'h0001, 3'd4, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== L_SHL1) begin failures++; $display("FAIL shl_lat: got %0d required %0d", lat, L_SHL1); end
        checks++; if (wd !== 16'h0002) begin failures++; $display("FAIL shl_data: got %h required 0002", wd); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL shl_carry: got %b required 1", c); end
        issue(3'b110, 16'h8001, 16'h0013, 3'd5, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== L_SHR3) begin failures++; $display("FAIL shr_lat: got %0d required %0d", lat, L_SHR3); end
        checks++; if (wd !== 16'h1000) begin failures++; $display("FAIL shr_data: got %h required 1000", wd); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL shr_carry: got %b required 0", c); end
        issue(3'b110, 16'h0007, 16'h0002, 3'd5, lat, ws, wd, z, c, wl, bz);
        checks++; if ({wd, c} !== {16'h0001, 1'b1}) begin failures++; $display("FAIL shr2_result: got %h carry=%b required 0001 1", wd, c); end
        issue(3'b101, 16'h1234, 16'h0010, 3'd7, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== 2) begin failures++; $display("FAIL shl0_lat: got %0d required 2", lat); end
        checks++; if ({wd, c} !== {16'h1234, 1'b0}) begin failures++; $display("FAIL shl0_result: got %h carry=%b required 1234 0", wd, c); end
    endtask

    task automatic test_mul();
        int lat; logic [2:0] ws; logic [15:0] wd; logic z, c, wl, bz;
        issue(3'b111, 16'h0123, 16'h0010, 3'd2, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== 17) begin failures++; $display("FAIL mul_lat: got %0d required 17", lat); end
        checks++; if (wd !== 16'h1230) begin failures++; $display("FAIL mul_data: got %h required 1230", wd); end
        checks++; if ({z, c} !== 2'b00) begin failures++; $display("FAIL mul_flags: got zero=%b carry=%b required 0 0", z, c); end
        checks++; if (wl !== 1'b0) begin failures++; $display("FAIL mul_pulse: got wbLoad=%b next cycle required 0", wl); end
        issue(3'b111, 16'h0100, 16'h0100, 3'd7, lat, ws, wd, z, c, wl, bz);
        checks++; if (wd !== 16'h0000) begin failures++; $display("FAIL mul_ovf_data: got %h required 0000", wd); end
        checks++; if ({z, c} !== 2'b11) begin failures++; $display("FAIL mul_ovf_flags: got zero=%b carry=%b required 1 1", z, c); end
        issue(3'b111, 16'hFFFF, 16'hFFFF, 3'd1, lat, ws, wd, z, c, wl, bz);
        checks++; if ({wd, c} !== {16'h0001, 1'b1}) begin failures++; $display("FAIL mul_max: got %h carry=%b required 0001 1", wd, c); end
    endtask

    task automatic test_back_to_back();
        int loads = 0;
        int n_sub = 0;
        logic [15:0] first = '0;
        logic prev = 1'b0;
        int dbl = 0;
        op = 3'b000; opA = 16'd10; opB = 16'd3; destSel = 3'd1; start = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            if (i == 0) op = 3'b001;
            if (i == 19) start = 1'b0;
            if (wbLoad) begin
                if (loads == 0) first = wbData;
                else if (wbData == 16'd7) n_sub++;
                loads++;
                if (prev) dbl++;
            end
            prev = wbLoad;
        end
        checks++; if (loads !== 7) begin failures++; $display("FAIL b2b_count: got %0d required 7", loads); end
        checks++; if (first !== 16'd13) begin failures++; $display("FAIL b2b_first: got %0d required 13", first); end
        checks++; if (n_sub !== 6) begin failures++; $display("FAIL b2b_sub: got %0d required 6", n_sub); end
        checks++; if (dbl !== 0) begin failures++; $display("FAIL b2b_pulse: got %0d double pulses required 0", dbl); end
    endtask

    task automatic test_mid_reset();
        int lat; logic [2:0] ws; logic [15:0] wd; logic z, c, wl, bz;
        int loads = 0;
        issue(3'b000, 16'hFFFF, 16'h0002, 3'd5, lat, ws, wd, z, c, wl, bz);
        op = 3'b111; opA = 16'h0123; opB = 16'h0010; destSel = 3'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbLoad) loads++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, wbLoad, wbSel, wbData, zero, carry} !== 22'd0) begin
            failures++;
            $display("FAIL midrst_outputs: got busy=%b wbLoad=%b wbSel=%0d wbData=%h zero=%b carry=%b required all 0",
                     busy, wbLoad, wbSel, wbData, zero, carry);
        end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (wbLoad) loads++;
        end
        checks++; if (loads !== 0) begin failures++; $display("FAIL midrst_noload: got %0d loads required 0", loads); end
        issue(3'b000, 16'h0002, 16'h0003, 3'd2, lat, ws, wd, z, c, wl, bz);
        checks++; if (lat !== 2) begin failures++; $display("FAIL midrst_add_lat: got %0d required 2", lat); end
        checks++; if ({ws, wd} !== {3'd2, 16'h0005}) begin failures++; $display("FAIL midrst_add: got sel=%0d data=%h required 2 0005", ws, wd); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_xor();
        test_shift();
        test_mul();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
